// File: rtl/bbc_kbd_pkg.sv
// Shared constants, key-location type and the PS/2 set-2 to BBC matrix map.
package bbc_kbd_pkg;

    localparam int         FRAME_BITS  = 11;
    localparam int         NUM_COLS    = 10;
    localparam int         NUM_ROWS    = 8;
    localparam logic [7:0] SC_BREAK    = 8'hF0;
    localparam logic [7:0] SC_EXTENDED = 8'hE0;

    typedef struct packed {
        logic       valid;
        logic [2:0] row;
        logic [3:0] col;
    } key_loc_t;

    // BBC key number: row in the high nibble, column in the low nibble.
    function automatic key_loc_t scancode_to_key(input logic [7:0] code);
        key_loc_t   loc;
        logic [7:0] key;
        logic       hit;
        hit = 1'b1;
        key = 8'h00;
        case (code)
            8'h12, 8'h59: key = 8'h00;
            8'h14: key = 8'h01;
            8'h15: key = 8'h10;
            8'h26: key = 8'h11;
            8'h25: key = 8'h12;
            8'h2E: key = 8'h13;
            8'h0C: key = 8'h14;
            8'h3E: key = 8'h15;
            8'h83: key = 8'h16;
            8'h4E: key = 8'h17;
            8'h55: key = 8'h18;
            8'h6B: key = 8'h19;
            8'h09: key = 8'h20;
            8'h1D: key = 8'h21;
            8'h24: key = 8'h22;
            8'h2C: key = 8'h23;
            8'h3D: key = 8'h24;
            8'h43: key = 8'h25;
            8'h46: key = 8'h26;
            8'h45: key = 8'h27;
            8'h0E: key = 8'h28;
            8'h72: key = 8'h29;
            8'h16: key = 8'h30;
            8'h1E: key = 8'h31;
            8'h23: key = 8'h32;
            8'h2D: key = 8'h33;
            8'h36: key = 8'h34;
            8'h3C: key = 8'h35;
            8'h44: key = 8'h36;
            8'h4D: key = 8'h37;
            8'h54: key = 8'h38;
            8'h75: key = 8'h39;
            8'h58: key = 8'h40;
            8'h1C: key = 8'h41;
            8'h22: key = 8'h42;
            8'h2B: key = 8'h43;
            8'h35: key = 8'h44;
            8'h3B: key = 8'h45;
            8'h42: key = 8'h46;
            8'h52: key = 8'h47;
            8'h4C: key = 8'h48;
            8'h5A: key = 8'h49;
            8'h11: key = 8'h50;
            8'h1B: key = 8'h51;
            8'h21: key = 8'h52;
            8'h34: key = 8'h53;
            8'h33: key = 8'h54;
            8'h31: key = 8'h55;
            8'h4B: key = 8'h56;
            8'h5D: key = 8'h57;
            8'h5B: key = 8'h58;
            8'h66: key = 8'h59;
            8'h0D: key = 8'h60;
            8'h1A: key = 8'h61;
            8'h29: key = 8'h62;
            8'h2A: key = 8'h63;
            8'h32: key = 8'h64;
            8'h3A: key = 8'h65;
            8'h41: key = 8'h66;
            8'h49: key = 8'h67;
            8'h4A: key = 8'h68;
            8'h69: key = 8'h69;
            8'h76: key = 8'h70;
            8'h05: key = 8'h71;
            8'h06: key = 8'h72;
            8'h04: key = 8'h73;
            8'h03: key = 8'h74;
            8'h0B: key = 8'h75;
            8'h0A: key = 8'h76;
            8'h01: key = 8'h77;
            8'h61: key = 8'h78;
            8'h74: key = 8'h79;
            default: hit = 1'b0;
        endcase
        loc.valid = hit;
        loc.row   = key[6:4];
        loc.col   = key[3:0];
        return loc;
    endfunction

endpackage

// File: rtl/bbc_keyboard_ps2_rx.sv
// PS/2 device-to-host receiver: synchronises the pins, shifts in 11-bit
// frames on falling clock edges and emits a one-clock strobe per good byte.
module ps2_rx
    import bbc_kbd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16384
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       byte_valid_o,
    output logic [7:0] byte_data_o
);

    localparam int            TW           = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]    LAST_BIT     = 4'(FRAME_BITS - 1);

    logic [1:0]    clkSync_q;
    logic [1:0]    dataSync_q;
    logic          clkPrev_q;
    logic [3:0]    bitCnt_q, bitCnt_d;
    logic [9:0]    shift_q, shift_d;
    logic [TW-1:0] idleCnt_q, idleCnt_d;
    logic          byteValid_q, byteValid_d;
    logic [7:0]    byteData_q, byteData_d;

    logic          fallEdge;
    logic [10:0]   frame;
    logic          frameOk;

    assign fallEdge = clkPrev_q & ~clkSync_q[1];
    assign frame    = {dataSync_q[1], shift_q};
    assign frameOk  = ~frame[0] & (^frame[9:1]) & frame[10];

    // Two-flop synchronisers plus the delayed clock used for edge detection; idle level is high.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            clkSync_q  <= 2'b11;
            dataSync_q <= 2'b11;
            clkPrev_q  <= 1'b1;
        end else begin
            clkSync_q  <= {clkSync_q[0], ps2_clk_i};
            dataSync_q <= {dataSync_q[0], ps2_data_i};
            clkPrev_q  <= clkSync_q[1];
        end
    end

    // Frame assembly: shift on each falling edge, validate on the 11th bit, drop stalled frames.
    always_comb begin
        bitCnt_d    = bitCnt_q;
        shift_d     = shift_q;
        idleCnt_d   = idleCnt_q;
        byteValid_d = 1'b0;
        byteData_d  = byteData_q;
        if (fallEdge) begin
            shift_d   = frame[10:1];
            idleCnt_d = '0;
            if (bitCnt_q == LAST_BIT) begin
                bitCnt_d = 4'd0;
                if (frameOk) begin
                    byteValid_d = 1'b1;
                    byteData_d  = frame[8:1];
                end
            end else begin
                bitCnt_d = bitCnt_q + 4'd1;
            end
        end else if (bitCnt_q != 4'd0) begin
            if (idleCnt_q == TIMEOUT_LAST) begin
                bitCnt_d  = 4'd0;
                idleCnt_d = '0;
            end else begin
                idleCnt_d = idleCnt_q + 1'b1;
            end
        end else begin
            idleCnt_d = '0;
        end
    end

    // Receiver state registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            bitCnt_q    <= 4'd0;
            shift_q     <= '0;
            idleCnt_q   <= '0;
            byteValid_q <= 1'b0;
            byteData_q  <= 8'h00;
        end else begin
            bitCnt_q    <= bitCnt_d;
            shift_q     <= shift_d;
            idleCnt_q   <= idleCnt_d;
            byteValid_q <= byteValid_d;
            byteData_q  <= byteData_d;
        end
    end

    assign byte_valid_o = byteValid_q;
    assign byte_data_o  = byteData_q;

endmodule

// File: rtl/bbc_keyboard.sv
// BBC Micro keyboard matrix driven from a PS/2 keyboard, with the CPU
// row/column probe and the autoscan column counter feeding CA2.
module bbc_keyboard
    import bbc_kbd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16384
) (
    input  logic       CLK_hPROC,
    input  logic       RESET,
    input  logic       autoscan,
    input  logic [3:0] column,
    input  logic [2:0] row,
    input  logic       PS2_CLK,
    input  logic       PS2_DATA,
    output logic       column_match,
    output logic       row_match
);

    logic                         byteValid;
    logic [7:0]                   byteData;
    key_loc_t                     loc;

    logic                         breakFlag_q, breakFlag_d;
    logic                         extFlag_q, extFlag_d;
    logic [NUM_COLS-1:0][7:0]     matrix_q, matrix_d;
    logic [3:0]                   colCnt_q, colCnt_d;

    logic [7:0]                   probeBits;
    logic [6:0]                   scanBits;

    ps2_rx #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_rx (
        .clk_i       (CLK_hPROC),
        .reset_i     (RESET),
        .ps2_clk_i   (PS2_CLK),
        .ps2_data_i  (PS2_DATA),
        .byte_valid_o(byteValid),
        .byte_data_o (byteData)
    );

    assign loc = scancode_to_key(byteData);

    // Byte interpretation: prefixes set flags, any other byte updates the matrix and clears them.
    always_comb begin
        breakFlag_d = breakFlag_q;
        extFlag_d   = extFlag_q;
        matrix_d    = matrix_q;
        colCnt_d    = autoscan ? colCnt_q + 4'd1 : column;
        if (byteValid) begin
            if (byteData == SC_BREAK) begin
                breakFlag_d = 1'b1;
            end else if (byteData == SC_EXTENDED) begin
                extFlag_d = 1'b1;
            end else begin
                if (loc.valid && (loc.col < 4'(NUM_COLS))) begin
                    matrix_d[loc.col][loc.row] = ~breakFlag_q;
                end
                breakFlag_d = 1'b0;
                extFlag_d   = 1'b0;
            end
        end
    end

    // Key matrix, prefix flags and the scan column counter.
    always_ff @(posedge CLK_hPROC) begin
        if (RESET) begin
            breakFlag_q <= 1'b0;
            extFlag_q   <= 1'b0;
            matrix_q    <= '0;
            colCnt_q    <= 4'd0;
        end else begin
            breakFlag_q <= breakFlag_d;
            extFlag_q   <= extFlag_d;
            matrix_q    <= matrix_d;
            colCnt_q    <= colCnt_d;
        end
    end

    // Column reads: columns 10-15 are empty and the row-0 startup links read as open.
    always_comb begin
        probeBits = 8'h00;
        scanBits  = 7'h00;
        if (column < 4'(NUM_COLS)) begin
            probeBits = matrix_q[column];
        end
        if (column >= 4'd2) begin
            probeBits[0] = 1'b0;
        end
        if (colCnt_q < 4'(NUM_COLS)) begin
            scanBits = matrix_q[colCnt_q][7:1];
        end
    end

    assign row_match    = probeBits[row];
    assign column_match = |scanBits;

endmodule

// File: tb/tb_bbc_keyboard.sv
// Directed bench for bbc_keyboard: PS/2 frames in, probe/scan outputs checked.
module tb_bbc_keyboard;

    localparam int TB_TIMEOUT = 200;

    logic       clk;
    logic       reset;
    logic       autoscan;
    logic [3:0] column;
    logic [2:0] row;
    logic       ps2Clk;
    logic       ps2Data;
    logic       columnMatch;
    logic       rowMatch;

    int testsRun    = 0;
    int testsFailed = 0;

    bbc_keyboard #(
        .TIMEOUT_CYCLES(TB_TIMEOUT)
    ) dut (
        .CLK_hPROC   (clk),
        .RESET       (reset),
        .autoscan    (autoscan),
        .column      (column),
        .row         (row),
        .PS2_CLK     (ps2Clk),
        .PS2_DATA    (ps2Data),
        .column_match(columnMatch),
        .row_match   (rowMatch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges and settle just after the last one.
    task automatic waitClocks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Send the first nBits of a PS/2 frame; each bit is 4 clocks high then 4 clocks low.
    task automatic applyStimulus(input logic [7:0] code, input bit badParity, input int nBits);
        logic [10:0] frame;
        frame = {1'b1, (~^code) ^ badParity, code, 1'b0};
        for (int i = 0; i < nBits; i++) begin
            ps2Data = frame[i];
            waitClocks(4);
            ps2Clk = 1'b0;
            waitClocks(4);
            ps2Clk = 1'b1;
        end
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        autoscan = 1'b1;
        column   = 4'd0;
        row      = 3'd0;
        ps2Clk   = 1'b1;
        ps2Data  = 1'b1;
        waitClocks(3);
        @(negedge clk);
        testsRun++;
        if (rowMatch !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset_row_match: got %b expected 0", rowMatch);
        end
        testsRun++;
        if (columnMatch !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset_column_match: got %b expected 0", columnMatch);
        end
        waitClocks(1);
        reset = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            testsRun++;
            if (columnMatch !== 1'b0 || rowMatch !== 1'b0) begin
                testsFailed++;
                $display("[TB] FAIL idle_scan clk %0d: got col=%b row=%b expected 0/0", i, columnMatch, rowMatch);
            end
        end
    endtask

    task automatic test_make_break();
        applyStimulus(8'h4D, 1'b0, 11);
        autoscan = 1'b0;
        column   = 4'd7;
        row      = 3'd3;
        waitClocks(2);
        @(negedge clk);
        testsRun++;
        if (rowMatch !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL P_make_row: got %b expected 1", rowMatch);
        end
        testsRun++;
        if (columnMatch !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL P_make_column: got %b expected 1", columnMatch);
        end
        row = 3'd2;
        #1;
        testsRun++;
        if (rowMatch !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL P_other_row: got %b expected 0", rowMatch);
        end
        row = 3'd3;
        applyStimulus(8'hF0, 1'b0, 11);
        @(negedge clk);
        testsRun++;
        if (rowMatch !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL P_after_F0: got %b expected 1", rowMatch);
        end
        applyStimulus(8'h4D, 1'b0, 11);
        @(negedge clk);
        testsRun++;
        if (rowMatch !== 1'b0 || columnMatch !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL P_break: got row=%b col=%b expected 0/0", rowMatch, columnMatch);
        end
    endtask

    task automatic test_autoscan();
        applyStimulus(8'h5A, 1'b0, 11);
        autoscan = 1'b0;
        column   = 4'd0;
        waitClocks(1);
        autoscan = 1'b1;
        for (int i = 0; i < 48; i++) begin
            @(negedge clk);
            testsRun++;
            if (columnMatch !== ((i % 16) == 9)) begin
                testsFailed++;
                $display("[TB] FAIL scan_return clk %0d: got %b expected %b", i, columnMatch, (i % 16) == 9);
            end
        end
        autoscan = 1'b0;
        column   = 4'd9;
        row      = 3'd4;
        waitClocks(1);
        @(negedge clk);
        testsRun++;
        if (rowMatch !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL return_probe: got %b expected 1", rowMatch);
        end
        applyStimulus(8'hF0, 1'b0, 11);
        applyStimulus(8'h5A, 1'b0, 11);
        @(negedge clk);
        testsRun++;
        if (rowMatch !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL return_break: got %b expected 0", rowMatch);
        end
    endtask

    task automatic test_shift();
        applyStimulus(8'h12, 1'b0, 11);
        autoscan = 1'b0;
        row      = 3'd0;
        for (int c = 0; c < 16; c++) begin
            column = 4'(c);
            waitClocks(1);
            @(negedge clk);
            testsRun++;
            if (columnMatch !== 1'b0 || rowMatch !== (c == 0)) begin
                testsFailed++;
                $display("[TB] FAIL shift col %0d: got col=%b row=%b expected 0/%b", c, columnMatch, rowMatch, c == 0);
            end
        end
        column = 4'd0;
        applyStimulus(8'hF0, 1'b0, 11);
        applyStimulus(8'h12, 1'b0, 11);
        @(negedge clk);
        testsRun++;
        if (rowMatch !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL shift_break: got %b expected 0", rowMatch);
        end
    endtask

    task automatic test_bad_frames();
        autoscan = 1'b0;
        column   = 4'd2;
        row      = 3'd6;
        applyStimulus(8'h29, 1'b1, 11);
        @(negedge clk);
        testsRun++;
        if (rowMatch !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL bad_parity: got %b expected 0", rowMatch);
        end
        applyStimulus(8'h29, 1'b0, 5);
        waitClocks(TB_TIMEOUT + 50);
        @(negedge clk);
        testsRun++;
        if (rowMatch !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL stalled_frame: got %b expected 0", rowMatch);
        end
        applyStimulus(8'h29, 1'b0, 11);
        @(negedge clk);
        testsRun++;
        if (rowMatch !== 1'b1 || columnMatch !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL space_after_timeout: got row=%b col=%b expected 1/1", rowMatch, columnMatch);
        end
        applyStimulus(8'hF0, 1'b0, 11);
        applyStimulus(8'h29, 1'b0, 11);
        @(negedge clk);
        testsRun++;
        if (rowMatch !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL space_break: got %b expected 0", rowMatch);
        end
    endtask

    task automatic test_reset_mid();
        autoscan = 1'b0;
        column   = 4'd1;
        row      = 3'd1;
        applyStimulus(8'h26, 1'b0, 11);
        @(negedge clk);
        testsRun++;
        if (rowMatch !== 1'b1 || columnMatch !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL three_make: got row=%b col=%b expected 1/1", rowMatch, columnMatch);
        end
        reset = 1'b1;
        waitClocks(3);
        reset = 1'b0;
        @(negedge clk);
        testsRun++;
        if (rowMatch !== 1'b0 || columnMatch !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL three_reset: got row=%b col=%b expected 0/0", rowMatch, columnMatch);
        end
        applyStimulus(8'hF0, 1'b0, 11);
        applyStimulus(8'h26, 1'b0, 11);
        @(negedge clk);
        testsRun++;
        if (rowMatch !== 1'b0 || columnMatch !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL three_late_break: got row=%b col=%b expected 0/0", rowMatch, columnMatch);
        end
        applyStimulus(8'h3D, 1'b0, 4);
        reset = 1'b1;
        waitClocks(2);
        reset  = 1'b0;
        column = 4'd0;
        row    = 3'd3;
        applyStimulus(8'h16, 1'b0, 11);
        @(negedge clk);
        testsRun++;
        if (rowMatch !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL one_after_abort: got %b expected 1", rowMatch);
        end
        column = 4'd4;
        row    = 3'd2;
        #1;
        testsRun++;
        if (rowMatch !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL seven_not_pressed: got %b expected 0", rowMatch);
        end
    endtask

    // Scenario sequence followed by the summary line.
    initial begin
        test_reset();
        test_make_break();
        test_autoscan();
        test_shift();
        test_bad_frames();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/bbc_keyboard.md
# bbc_keyboard

- Emulates the BBC Micro keyboard matrix: 10 columns × 8 rows of key switches, driven from a PS/2 keyboard.
- PS/2 make/break codes are decoded into a pressed-key matrix.
- The matrix is exposed to the system VIA through two paths:
  - a CPU-driven row/column probe (row_match);
  - a hardware autoscan column counter (column_match, wired to CA2 to raise the keypress interrupt).
- Sits between the PS/2 pins and VIA port A / CA2.

## Interface
Parameters:
- TIMEOUT_CYCLES, 16384: clock cycles without a PS/2 falling edge before a partial frame is discarded.

Ports:
- CLK_hPROC  in  1  sole clock (half processor rate); PS2_CLK is sampled by it, never used as a clock.
- RESET  in  1  reset; synchronous, active-high.
- autoscan  in  1  1 = free-running column scan; 0 = CPU selects the column.
- column  in  4  CPU column select (VIA PA[3:0]).
- row  in  3  CPU row select (VIA PA[6:4]).
- PS2_CLK  in  1  PS/2 clock line, asynchronous.
- PS2_DATA  in  1  PS/2 data line, asynchronous.
- column_match  out  1  any key pressed in rows 1–7 of the active column.
- row_match  out  1  key at (row, column) pressed (VIA PA7).

## Operation
- Key state: a 10×8 bit matrix, bit = 1 when the key is pressed.
  - Columns 10–15 always read 0.
  - Row 0, columns 2–9 (startup links) always read 0.
- Active column:
  - autoscan=1: internal 4-bit counter; +1 every clock, wraps 15→0.
  - autoscan=0: the counter loads `column` every clock, so active column = `column`.
- row_match = matrix[column][row]. Combinational from registers; always uses the `column` input.
- column_match = OR of matrix[active column][rows 7:1]. Combinational; row 0 (SHIFT/CTRL) is excluded.
- PS/2 receiver:
  - PS2_CLK and PS2_DATA each pass through a 2-FF synchroniser; a falling edge of synchronised PS2_CLK samples DATA.
  - Frame = 11 bits: start 0, 8 data bits LSB first, odd parity, stop 1.
  - A frame is accepted only if start=0, parity is odd over data+parity, and stop=1. Otherwise it is discarded silently.
- Byte handling:
  - 0xF0: set the break flag.
  - 0xE0: set the extended flag.
  - Any other byte: look it up in the scancode→(row,col) map. If mapped, set the matrix bit (break flag clear) or clear it (break flag set). Then clear both flags. Unmapped codes only clear the flags.
- Map uses BBC key numbers, row in the high nibble, column in the low nibble. Required entries include:
  - 12/59 SHIFT→00, 14 CTRL→01, 5A RETURN→49, 29 SPACE→62.
  - 4D P→37, 2D R→33, 43 I→25, 31 N→55, 2C T→23.
  - 3D 7→24, 26 3→11, 4E -→17, 16 1→30, 1E 2→31.
  - Remaining entries follow the standard UK BBC layout.
- Extended codes use the same map (e.g. E0 14 = CTRL).

## Timing
- Reset clears: matrix, counter, bit counter, shift register, break/extended flags, timeout counter. Hence column_match=0 and row_match=0 during and after reset.
- Matrix update occurs on the clock after the 11th falling edge is detected. Total latency from the PS2_CLK pin edge is at most 4 clocks (2 sync + edge detect + write).
- Timeout: mid-frame, if TIMEOUT_CYCLES pass with no falling edge, the bit counter returns to 0 and the flags are kept.
- Switching autoscan 1→0: the counter takes `column` on the same clock edge.
- Reset asserted mid-frame aborts the frame. The first edge after reset is treated as a start bit.
- A make for an already-pressed key and a break for a released key are idempotent.

## Structure
- Package bbc_kbd_pkg holds: frame length (11), F0/E0 constants, and a function scancode_to_key(byte) → {valid, row[2:0], col[3:0]} containing the full map.
- Sub-module ps2_rx: synchroniser, edge detect, shift/bit counter, parity/stop check, timeout. Outputs a 1-clock strobe `byte_valid` with `byte_data`.
- Top level contains: flags, matrix, counter, match logic.

## Test plan
- Reset, then idle PS/2 lines high → column_match=0, row_match=0; counter cycles 0..15 with autoscan=1.
- Send 4D, autoscan=0, column=7, row=3 → row_match=1, column_match=1. Send F0 4D → both 0 within 4 clocks of the final edge.
- Hold 5A with autoscan=1 → column_match pulses 1 exactly on clocks where the counter=9, once per 16 clocks.
- Send 12 (SHIFT) → row_match=1 at row 0/column 0, but column_match=0 in every column.
- Frame with bad parity for 29, and separately a frame stalled after 5 bits beyond TIMEOUT_CYCLES then a good 29 frame → matrix[2][6] stays 0 after the bad frame and becomes 1 only after the good frame.
- Assert RESET between make and break of 26 → matrix clears; the later F0 26 leaves all outputs 0.
